// File: rtl/core6_mem_arbiter.sv
// core6_mem_arbiter: round-robin arbiter that lets NUM_REQ cores share one
// single-port RAM at one access per cycle. Grants are combinational, read
// data returns one cycle later as a per-requester strobe.
// Optional feature macro: CORE6_MEM_ARB_LOCK_EN adds req_lock, which lets the
// granted core keep the RAM until it drops its lock.
module core6_mem_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_address,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_byteenable,
  input  logic [NUM_REQ-1:0]           req_read,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*DATA_W-1:0]    req_writedata,
`ifdef CORE6_MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           req_lock,
`endif
  output logic [NUM_REQ-1:0]           req_waitrequest,
  output logic [NUM_REQ-1:0]           req_readdatavalid,
  output logic [DATA_W-1:0]            req_readdata,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W/8-1:0]          mem_byteenable,
  output logic                         mem_chipselect,
  output logic                         mem_write,
  output logic [DATA_W-1:0]            mem_writedata,
  output logic                         mem_clken,
  input  logic [DATA_W-1:0]            mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {IDLE, LOCKED} state_e;

  state_e                          state_q, state_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [PTR_W-1:0]                owner_q, owner_d;
  logic [NUM_REQ-1:0]              rdv_q, rdv_d;

  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_a;
  logic [NUM_REQ-1:0][BE_W-1:0]    be_a;
  logic [NUM_REQ-1:0][DATA_W-1:0]  wd_a;
  logic [NUM_REQ-1:0]              pend;
  logic [NUM_REQ-1:0]              lock_w;
  logic [NUM_REQ-1:0]              gnt_oh;
  logic [PTR_W:0]                  sum;
  logic                            rr_vld;
  logic [PTR_W-1:0]                rr_idx;
  logic                            hold;
  logic                            gnt_vld;
  logic [PTR_W-1:0]                gnt_idx;

  assign addr_a = req_address;
  assign be_a   = req_byteenable;
  assign wd_a   = req_writedata;
  // read+write together counts as a write; either makes the core pending
  assign pend   = req_read | req_write;

`ifdef CORE6_MEM_ARB_LOCK_EN
  assign lock_w = req_lock;
`else
  assign lock_w = '0;
`endif

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // first pending requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!rr_vld && pend[sum[PTR_W-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = sum[PTR_W-1:0];
      end
    end
  end

  // grant select: a held lock pins the grant to its owner; reset masks all
  always_comb begin
    hold    = (state_q == LOCKED) && lock_w[owner_q];
    gnt_idx = hold ? owner_q : rr_idx;
    gnt_vld = reset_n && (hold ? pend[owner_q] : rr_vld);
  end

  // per-lane grant decode, waitrequest and reset-masked readdatavalid
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign gnt_oh[i]            = gnt_vld && (gnt_idx == PTR_W'(i));
    assign req_waitrequest[i]   = ~gnt_oh[i];
    // a read granted just before reset must not strobe during reset
    assign req_readdatavalid[i] = rdv_q[i] & reset_n;
  end

  // RAM side: granted requester's fields; strobes low when nothing granted
  always_comb begin
    mem_address    = addr_a[gnt_idx];
    mem_byteenable = be_a[gnt_idx];
    mem_writedata  = wd_a[gnt_idx];
    mem_chipselect = gnt_vld;
    mem_write      = gnt_vld & req_write[gnt_idx];
    mem_clken      = reset_n;
    req_readdata   = mem_readdata;
  end

  // next-state: ptr advances past every grant except those made under a held lock
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rdv_d   = gnt_oh & ~req_write;
    if (!hold) begin
      state_d = IDLE;
      if (gnt_vld) begin
        ptr_d = inc_ptr(gnt_idx);
        if (lock_w[gnt_idx]) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end
    end
  end

  // state, pointer and one-deep read-return pipe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      rdv_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rdv_q   <= rdv_d;
    end
  end

endmodule

// File: doc/core6_mem_arbiter.md
CORE6_MEM_ARBITER -- requirements
Module: core6_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6: number of requester ports (cores).
REQ-002 Parameter ADDR_W, default 13: word address width of the shared RAM.
REQ-003 Parameter DATA_W, default 32: data width, with byteenable width DATA_W/8.
REQ-004 clk  in  1: the single clock; all logic rises on its rising edge.
REQ-005 reset_n  in  1: synchronous, active-low reset.
REQ-006 req_address  in  NUM_REQ*ADDR_W: per-requester word address; slice i belongs to requester i.
REQ-007 req_byteenable  in  NUM_REQ*DATA_W/8: per-requester byte lanes.
REQ-008 req_read  in  NUM_REQ: read request per requester.
REQ-009 req_write  in  NUM_REQ: write request per requester.
REQ-010 req_writedata  in  NUM_REQ*DATA_W: per-requester write data.
REQ-011 req_waitrequest  out  NUM_REQ: high means the request is not accepted this cycle.
REQ-012 req_readdatavalid  out  NUM_REQ: one-cycle strobe marking return data for requester i.
REQ-013 req_readdata  out  DATA_W: read data, broadcast to all requesters and qualified by req_readdatavalid.
REQ-014 req_lock  in  NUM_REQ: hold-grant request; present only when CORE6_MEM_ARB_LOCK_EN is defined.
REQ-015 mem_address  out  ADDR_W: address to the single-port RAM.
REQ-016 mem_byteenable  out  DATA_W/8: byte lanes to the RAM.
REQ-017 mem_chipselect  out  1: RAM access strobe.
REQ-018 mem_write  out  1: RAM write strobe.
REQ-019 mem_writedata  out  DATA_W: write data to the RAM.
REQ-020 mem_clken  out  1: RAM clock enable.
REQ-021 mem_readdata  in  DATA_W: RAM output; valid one cycle after the address is accepted (address registered, output unregistered).

Function
REQ-022 Requester i is pending when req_read[i] or req_write[i] is high; if both are high, the request SHALL be treated as a write.
REQ-023 Arbitration SHALL be round-robin using a registered pointer ptr: the first pending requester searching ptr, ptr+1, ... (mod NUM_REQ) is granted in the same cycle.
REQ-024 Arbitration SHALL grant at most one requester per cycle; req_waitrequest SHALL be low only for the granted requester and high for all others, pending or not.
REQ-025 The mem_* outputs SHALL combinationally carry the granted requester's fields, with mem_chipselect=1 and mem_write set from that requester's write request.
REQ-026 If no requester is pending, mem_chipselect and mem_write SHALL be 0.
REQ-027 After each grant g, ptr SHALL become (g+1) mod NUM_REQ on the next edge, wrapping from NUM_REQ-1 to 0; with no grant, ptr holds.
REQ-028 When a read is granted in cycle N, req_readdatavalid[g] SHALL be 1 in cycle N+1 only, with req_readdata=mem_readdata.
REQ-029 A granted write SHALL produce no readdatavalid.
REQ-030 Back-to-back grants SHALL be sustained: one access per cycle, with 100% RAM utilisation while any request is pending.
REQ-031 A read granted in cycle N+1 SHALL NOT disturb the readdatavalid of a read granted in cycle N.
REQ-032 mem_clken SHALL be 1 whenever reset_n is 1.
REQ-033 The FSM SHALL have states IDLE and LOCKED; without the macro it remains in IDLE permanently.
REQ-034 A deasserted request that was never granted SHALL be dropped silently, with no state change.

Reset
REQ-035 While reset_n=0 at a clock edge, the following SHALL be set: ptr=0, state=IDLE, req_readdatavalid=0, all req_waitrequest=1, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-036 A read granted in the cycle before reset is asserted SHALL have its readdatavalid suppressed.
REQ-037 The first grant after reset release SHALL search from requester 0.

Configuration
REQ-038 Defining CORE6_MEM_ARB_LOCK_EN SHALL add the req_lock port and the following behaviour:
- If the granted requester g has req_lock[g]=1, the FSM SHALL move IDLE->LOCKED.
- In LOCKED, only g SHALL be granted; ptr SHALL NOT advance.
- When req_lock[g]=0, the FSM SHALL return LOCKED->IDLE, with ptr=(g+1) mod NUM_REQ.
REQ-039 Without CORE6_MEM_ARB_LOCK_EN, the req_lock port SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-040 Single read: req0 read addr 0x0010 with RAM word 0xDEADBEEF -> waitrequest[0]=0 in cycle N; readdatavalid[0]=1 with 0xDEADBEEF in N+1 only.
REQ-041 Contention: requesters 1, 3, 5 read continuously from ptr=0 -> grants follow 1,3,5,1,3,5; each waitrequest is low one cycle in three.
REQ-042 Wrap: ptr=5, requesters 0 and 5 pending -> 5 is granted, then 0; ptr goes 5->0->1.
REQ-043 Write then read: req2 writes 0x12345678 to 0x1FFF with byteenable 0xF, then reads 0x1FFF -> returns 0x12345678; byteenable 0x1 on a write of 0xAABBCCDD leaves 0x123456DD.
REQ-044 Reset mid-read: req4 read granted, reset_n=0 in the next cycle -> readdatavalid[4] stays 0; ptr=0 after release.
REQ-045 Lock (macro on): req1 holds lock for 4 grants while req2 is pending -> req2 is waited for 4 cycles, then granted the cycle after lock drops.
